alu_op_sequencer: RTL and testbench

//   Command-side driver for the 4-bit combinational ALU. Accepts one operation per command

---
 rtl/alu_op_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for the 4-bit combinational ALU: accepts a command, holds the ALU
// inputs for SETTLE_CYCLES, captures the result and returns it. Optional feature: ALU_ACC_CHAIN_EN.
module alu_op_sequencer #(
  parameter int unsigned DATA_W        = 4,
  parameter int unsigned SEL_W         = 3,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic              cmd_chain,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Counter reloads with SETTLE_CYCLES-1 and captures when it reaches zero.
  localparam int unsigned SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [SC_W-1:0]   settle_cnt;
  logic              accept;
  logic              capture;
  logic              consume;
  logic [DATA_W-1:0] a_src;

  // Next-state and transaction strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    consume = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept  = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == '0) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_valid && rsp_ready) begin
          consume = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef ALU_ACC_CHAIN_EN
  logic [DATA_W-1:0] acc;

  // Accumulator follows every captured result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (capture) begin
      acc <= alu_out;
    end
  end

  assign a_src = cmd_chain ? acc : cmd_a;
`else
  logic unused_chain;
  assign unused_chain = cmd_chain;
  assign a_src        = cmd_a;
`endif

  // State register and handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= (state_d == ST_IDLE);
      busy      <= (state_d != ST_IDLE);
    end
  end

  // ALU drive registers, held until the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      settle_cnt <= '0;
    end else if (accept) begin
      alu_a      <= a_src;
      alu_b      <= cmd_b;
      alu_sel    <= cmd_sel;
      settle_cnt <= SETTLE_LOAD;
    end else if (state_q == ST_SETTLE && settle_cnt != '0) begin
      settle_cnt <= settle_cnt - SC_W'(1);
    end
  end

  // Response capture, handshake and completion counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      op_count   <= '0;
    end else if (capture) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_out;
      rsp_carry  <= (alu_sel <= SEL_W'(1)) ? alu_carry : 1'b0;
      rsp_zero   <= (alu_out == '0);
    end else if (consume) begin
      rsp_valid  <= 1'b0;
      op_count   <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised self-checking bench for alu_op_sequencer with a behavioural ALU stand-in.
module tb_alu_op_sequencer;
  localparam int unsigned SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_chain;
  logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_out, rsp_result;
  logic [2:0] cmd_sel, alu_sel;
  logic       alu_carry, rsp_valid, rsp_ready, rsp_carry, rsp_zero, busy;
  logic [7:0] op_count;

  int   checks = 0;
  int   failures = 0;
  int   exp_count = 0;
  logic [3:0] last_res = 4'h0;
  bit   force_carry = 1'b0;
  logic [3:0] obs_res;
  logic       obs_carry, obs_zero;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(4), .SEL_W(3), .SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .alu_carry(alu_carry), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .busy(busy), .op_count(op_count)
  );

  // Arithmetic model of the ALU: returns {carry, result}
  function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    case (sel)
      3'd0: return 5'(ia + ib);
      3'd1: return {(ia < ib), 4'((ia - ib) & 15)};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, ~a};
      3'd6: return {a[3], 4'((ia * 2) & 15)};
      default: return {a[0], 4'(ia / 2)};
    endcase
  endfunction

  logic [4:0] alu_res;
  assign alu_res   = alu_model(alu_a, alu_b, alu_sel);
  assign alu_out   = alu_res[3:0];
  assign alu_carry = alu_res[4] | force_carry;

  // One full transaction, checking drive, latency, response, hold-off and completion
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                       input logic chain, input int hold);
    logic [3:0] a_eff;
    logic [4:0] r;
    logic       exp_c;
    int n;
`ifdef ALU_ACC_CHAIN_EN
    a_eff = chain ? last_res : a;
`else
    a_eff = a;
`endif
    r = alu_model(a_eff, b, sel);
    exp_c = (sel <= 3'd1) ? (r[4] | force_carry) : 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_chain = chain;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL cmd_ready_idle: got %b expected 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_chain = 1'b0;
    checks++;
    if ({alu_a, alu_b, alu_sel} !== {a_eff, b, sel}) begin
      failures++; $display("FAIL alu_drive: got a=%h b=%h sel=%h expected a=%h b=%h sel=%h", alu_a, alu_b, alu_sel, a_eff, b, sel);
    end
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++; $display("FAIL busy_settle: got busy=%b cmd_ready=%b expected 1/0", busy, cmd_ready);
    end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n != int'(SETTLE)) begin failures++; $display("FAIL latency: got %0d expected %0d", n, SETTLE); end
    obs_res = rsp_result; obs_carry = rsp_carry; obs_zero = rsp_zero;
    checks++;
    if ({rsp_result, rsp_carry, rsp_zero} !== {r[3:0], exp_c, (r[3:0] == 4'h0)}) begin
      failures++; $display("FAIL response: got res=%h c=%b z=%b expected res=%h c=%b z=%b",
                           rsp_result, rsp_carry, rsp_zero, r[3:0], exp_c, (r[3:0] == 4'h0));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_result, rsp_carry, rsp_zero, cmd_ready, busy} !==
          {1'b1, obs_res, obs_carry, obs_zero, 1'b0, 1'b1} || op_count !== 8'(exp_count)) begin
        failures++; $display("FAIL backpressure_hold: got v=%b res=%h rdy=%b busy=%b cnt=%0d expected v=1 res=%h rdy=0 busy=1 cnt=%0d",
                             rsp_valid, rsp_result, cmd_ready, busy, op_count, obs_res, exp_count);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count = (exp_count + 1) % 256;
    last_res  = r[3:0];
    checks++;
    if (op_count !== 8'(exp_count) || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL complete: got cnt=%0d v=%b rdy=%b busy=%b expected cnt=%0d v=0 rdy=1 busy=0",
                           op_count, rsp_valid, cmd_ready, busy, exp_count);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({cmd_ready, busy, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_carry, rsp_zero, op_count} !==
        {1'b1, 1'b0, 4'h0, 4'h0, 3'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h0}) begin
      failures++; $display("FAIL %s: got rdy=%b busy=%b a=%h b=%h sel=%h v=%b res=%h c=%b z=%b cnt=%0d expected reset values",
                           tag, cmd_ready, busy, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_carry, rsp_zero, op_count);
    end
  endtask

  task automatic test_reset();
    check_reset_values("reset_asserted");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset_released");
  endtask

  task automatic test_directed();
    do_op(4'h9, 4'h8, 3'd0, 1'b0, 0);
    checks++;
    if ({obs_res, obs_carry, obs_zero} !== {4'h1, 1'b1, 1'b0}) begin
      failures++; $display("FAIL add_9_8: got res=%h c=%b z=%b expected res=1 c=1 z=0", obs_res, obs_carry, obs_zero);
    end
    do_op(4'h3, 4'h5, 3'd1, 1'b0, 0);
    checks++;
    if ({obs_res, obs_carry} !== {4'hE, 1'b1}) begin
      failures++; $display("FAIL sub_3_5: got res=%h c=%b expected res=e c=1", obs_res, obs_carry);
    end
    force_carry = 1'b1;
    do_op(4'hC, 4'h3, 3'd2, 1'b0, 0);
    force_carry = 1'b0;
    checks++;
    if ({obs_res, obs_carry, obs_zero} !== {4'h0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL and_c_3: got res=%h c=%b z=%b expected res=0 c=0 z=1", obs_res, obs_carry, obs_zero);
    end
  endtask

  task automatic test_backpressure();
    do_op(4'h7, 4'h6, 3'd0, 1'b0, 5);
  endtask

  // Commands arriving while busy and rsp_ready without a response must have no effect
  task automatic test_ignored();
    int n;
    @(negedge clk);
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (op_count !== 8'(exp_count) || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL idle_rsp_ready: got cnt=%0d v=%b expected cnt=%0d v=0", op_count, rsp_valid, exp_count);
    end
    cmd_valid = 1'b1; cmd_a = 4'h1; cmd_b = 4'h2; cmd_sel = 3'd0; cmd_chain = 1'b0;
    @(negedge clk);
    cmd_a = 4'hF; cmd_b = 4'hF; cmd_sel = 3'd7;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if ({alu_a, alu_b, alu_sel, rsp_result, rsp_valid} !== {4'h1, 4'h2, 3'd0, 4'h3, 1'b1}) begin
      failures++; $display("FAIL busy_cmd_ignored: got a=%h b=%h sel=%h res=%h v=%b expected a=1 b=2 sel=0 res=3 v=1",
                           alu_a, alu_b, alu_sel, rsp_result, rsp_valid);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    exp_count = (exp_count + 1) % 256;
    last_res = 4'h3;
    @(negedge clk);
    checks++;
    if (alu_a !== 4'h1 || op_count !== 8'(exp_count) || busy !== 1'b0) begin
      failures++; $display("FAIL no_accept_on_consume: got a=%h cnt=%0d busy=%b expected a=1 cnt=%0d busy=0",
                           alu_a, op_count, busy, exp_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_mid_reset();
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = 4'h5; cmd_b = 4'h5; cmd_sel = 3'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    exp_count = 0; last_res = 4'h0;
    check_reset_values("reset_in_settle");
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("after_reset_settle");
    cmd_valid = 1'b1; cmd_a = 4'h2; cmd_b = 4'h1; cmd_sel = 3'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    rst = 1'b1; rsp_ready = 1'b1;
    #1;
    check_reset_values("reset_in_resp");
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("after_reset_resp");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) begin
      do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'b0, 0);
    end
    checks++;
    if (op_count !== 8'h00) begin failures++; $display("FAIL op_count_wrap: got %0d expected 0", op_count); end
  endtask

  task automatic test_chain();
    do_op(4'h2, 4'h3, 3'd0, 1'b0, 0);
    do_op(4'hF, 4'h4, 3'd0, 1'b1, 0);
    checks++;
`ifdef ALU_ACC_CHAIN_EN
    if ({obs_res, obs_carry} !== {4'h9, 1'b0}) begin
      failures++; $display("FAIL chain_add: got res=%h c=%b expected res=9 c=0", obs_res, obs_carry);
    end
`else
    if ({obs_res, obs_carry} !== {4'h3, 1'b1}) begin
      failures++; $display("FAIL chain_ignored: got res=%h c=%b expected res=3 c=1", obs_res, obs_carry);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_a = 4'h0; cmd_b = 4'h0; cmd_sel = 3'd0; cmd_chain = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_ignored();
    test_random();
    test_mid_reset();
    test_wrap();
    test_chain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
